lzma_window_match_finder: RTL and testbench

- Single-beat LZ match finder for the LZMA2 compression datapath. One instance sits in each parallel lane, ahead of the lane's range encoder.
- Each beat, it compares a 32-byte input window against the 32 bytes that precede it, supplied by the dictionary memory. It emits either the longest match (length, distance) or a literal for input byte 0.
- It also keeps a small 3-byte hash table and counts hash-bucket collisions and matches.

---
 rtl/lzma_window_match_finder.sv | 129 ++++++++++++
 tb/tb_lzma_window_match_finder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lzma_window_match_finder.sv
// lzma_window_match_finder
//   Single-beat LZ match finder for one LZMA2 lane. Each accepted beat compares
//   a 32-byte input window against the 32 dictionary bytes that precede it and
//   registers either the longest match (length, distance) or a literal for
//   input byte 0. A small 3-byte hash table tracks bucket collisions.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   data_in[255:0]       current window, byte k at [8k+7:8k]
//   data_valid           beat accepted when data_valid && ready
//   dictionary[255:0]    preceding 32 bytes; byte 31 directly precedes data byte 0
//   ready                accept enable, 1 from the first edge after reset
//   result_valid         one-cycle pulse per accepted beat
//   result_literal_flag  1 = literal, 0 = match
//   result_literal       data byte 0 (both result kinds)
//   result_length        match length, 0 for a literal
//   result_distance      match distance 1..32, 0 for a literal
//   match_count          number of match results emitted (wraps)
//   hash_collisions      number of hash-bucket collisions seen (wraps)
module lzma_window_match_finder #(
    parameter int WIN_BYTES = 32,
    parameter int MIN_MATCH = 3,
    parameter int HASH_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIN_BYTES*8-1:0] data_in,
    input  logic                   data_valid,
    input  logic [WIN_BYTES*8-1:0] dictionary,
    output logic                   ready,
    output logic                   result_valid,
    output logic                   result_literal_flag,
    output logic [7:0]             result_literal,
    output logic [5:0]             result_length,
    output logic [14:0]            result_distance,
    output logic [31:0]            match_count,
    output logic [31:0]            hash_collisions
);

    localparam int HENT = 1 << HASH_BITS;

    logic                   accept;
    logic [WIN_BYTES*16-1:0] stream;
    logic [5:0]             best_len;
    logic [5:0]             best_dist;
    logic [5:0]             cand_len;
    logic                   run;
    logic                   is_match;

    logic [7:0]             b0, b1, b2;
    logic [7:0]             hmix;
    logic [HASH_BITS-1:0]   h;
    logic [23:0]            key;
    logic                   collide;

    logic [HENT-1:0]        hvalid;
    logic [23:0]            hkey [HENT];

    assign accept = data_valid && ready;

    // Dictionary occupies the low half so that stream byte (32 - d + k) is the
    // candidate for data byte k at distance d, including self-overlap.
    assign stream = {data_in, dictionary};

    // Strict '>' while scanning d upward keeps the smallest distance on ties.
    always_comb begin
        best_len  = '0;
        best_dist = '0;
        cand_len  = '0;
        run       = 1'b0;
        for (int unsigned d = 1; d <= WIN_BYTES; d++) begin
            cand_len = '0;
            run      = 1'b1;
            for (int unsigned k = 0; k < WIN_BYTES; k++) begin
                if (run && (data_in[8*k +: 8] == stream[8*(WIN_BYTES-d+k) +: 8]))
                    cand_len = cand_len + 6'd1;
                else
                    run = 1'b0;
            end
            if (cand_len > best_len) begin
                best_len  = cand_len;
                best_dist = 6'(d);
            end
        end
    end

    assign is_match = (best_len >= 6'(MIN_MATCH));

    assign b0      = data_in[7:0];
    assign b1      = data_in[15:8];
    assign b2      = data_in[23:16];
    assign hmix    = b0 ^ {b1[3:0], b1[7:4]} ^ b2;
    assign h       = hmix[HASH_BITS-1:0];
    assign key     = {b2, b1, b0};
    assign collide = hvalid[h] && (hkey[h] != key);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready               <= 1'b0;
            result_valid        <= 1'b0;
            result_literal_flag <= 1'b0;
            result_literal      <= '0;
            result_length       <= '0;
            result_distance     <= '0;
            match_count         <= '0;
            hash_collisions     <= '0;
            hvalid              <= '0;
        end else begin
            ready        <= 1'b1;
            result_valid <= accept;
            if (accept) begin
                result_literal      <= b0;
                result_literal_flag <= !is_match;
                result_length       <= is_match ? best_len : 6'd0;
                result_distance     <= is_match ? {9'd0, best_dist} : 15'd0;
                match_count         <= match_count + {31'd0, is_match};
                hash_collisions     <= hash_collisions + {31'd0, collide};
                hvalid[h]           <= 1'b1;
            end
        end
    end

    // Keys need no reset: a key is only consulted when its valid bit is set.
    always_ff @(posedge clk) begin
        if (accept)
            hkey[h] <= key;
    end

endmodule

// File: tb/tb_lzma_window_match_finder.sv
// tb_lzma_window_match_finder
//   Directed bench for lzma_window_match_finder: a byte-level reference model
//   predicts every output each cycle; selected beats also carry hand-computed
//   expected values that pin the model.
module tb_lzma_window_match_finder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [255:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic [255:0] dictionary = '0;
    logic         ready;
    logic         result_valid;
    logic         result_literal_flag;
    logic [7:0]   result_literal;
    logic [5:0]   result_length;
    logic [14:0]  result_distance;
    logic [31:0]  match_count;
    logic [31:0]  hash_collisions;

    int n_cmp = 0;
    int n_bad = 0;

    lzma_window_match_finder #(
        .WIN_BYTES(32),
        .MIN_MATCH(3),
        .HASH_BITS(4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .data_in             (data_in),
        .data_valid          (data_valid),
        .dictionary          (dictionary),
        .ready               (ready),
        .result_valid        (result_valid),
        .result_literal_flag (result_literal_flag),
        .result_literal      (result_literal),
        .result_length       (result_length),
        .result_distance     (result_distance),
        .match_count         (match_count),
        .hash_collisions     (hash_collisions)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Best match as {length, distance}; length 0 / distance 0 when nothing hits.
    function automatic int best_of(input logic [255:0] dat, input logic [255:0] dict, input bit want_len);
        logic [7:0] st [64];
        int bl = 0;
        int bd = 0;
        for (int j = 0; j < 32; j++) begin
            st[j]      = dict[8*j +: 8];
            st[32 + j] = dat[8*j +: 8];
        end
        for (int d = 1; d <= 32; d++) begin
            int len = 0;
            while (len < 32 && st[32 + len] == st[32 - d + len]) len++;
            if (len > bl) begin
                bl = len;
                bd = d;
            end
        end
        return want_len ? bl : bd;
    endfunction

    function automatic int hidx(input logic [255:0] dat);
        int a = int'(dat[7:0]);
        int b = int'(dat[15:8]);
        int c = int'(dat[23:16]);
        return (a ^ c ^ (((b * 16) % 256) + (b / 16))) % 16;
    endfunction

    bit         m_ready = 0, m_valid = 0, m_flag = 0;
    logic [7:0] m_lit = '0;
    int         m_len = 0, m_dist = 0;
    logic [31:0] m_mc = '0, m_hc = '0;
    bit         mval [16];
    logic [23:0] mkey [16];

    // Pins supplied by the stimulus alongside a beat, latched with it.
    bit         pin_en = 0, pin_flag = 0;
    int         pin_len = 0, pin_dist = 0, pin_mc = 0, pin_hc = 0;
    logic [7:0] pin_lit = '0;
    bit         mp_en = 0, mp_flag = 0;
    int         mp_len = 0, mp_dist = 0, mp_mc = 0, mp_hc = 0;
    logic [7:0] mp_lit = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 0; m_valid <= 0; m_flag <= 0; m_lit <= '0;
            m_len <= 0; m_dist <= 0; m_mc <= '0; m_hc <= '0;
            mp_en <= 0;
            for (int i = 0; i < 16; i++) mval[i] <= 0;
        end else begin
            m_ready <= 1;
            m_valid <= 0;
            if (data_valid && m_ready) begin
                m_valid <= 1;
                m_lit   <= data_in[7:0];
                if (best_of(data_in, dictionary, 1) >= 3) begin
                    m_flag <= 0;
                    m_len  <= best_of(data_in, dictionary, 1);
                    m_dist <= best_of(data_in, dictionary, 0);
                    m_mc   <= m_mc + 1;
                end else begin
                    m_flag <= 1;
                    m_len  <= 0;
                    m_dist <= 0;
                end
                if (mval[hidx(data_in)] && mkey[hidx(data_in)] != data_in[23:0])
                    m_hc <= m_hc + 1;
                mval[hidx(data_in)] <= 1;
                mkey[hidx(data_in)] <= data_in[23:0];
                mp_en <= pin_en; mp_flag <= pin_flag; mp_len <= pin_len;
                mp_dist <= pin_dist; mp_lit <= pin_lit; mp_mc <= pin_mc; mp_hc <= pin_hc;
            end
        end
    end

    // ---------------- compare ----------------
    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if ($time > 1) begin
            chk("ready", ready, m_ready);
            chk("result_valid", result_valid, m_valid);
            chk("literal_flag", result_literal_flag, m_flag);
            chk("literal", result_literal, m_lit);
            chk("length", result_length, m_len);
            chk("distance", result_distance, m_dist);
            chk("match_count", match_count, m_mc);
            chk("hash_collisions", hash_collisions, m_hc);
            if (m_valid && mp_en) begin
                chk("pin_flag", result_literal_flag, mp_flag);
                chk("pin_length", result_length, mp_len);
                chk("pin_distance", result_distance, mp_dist);
                chk("pin_literal", result_literal, mp_lit);
                chk("pin_match_count", match_count, mp_mc);
                chk("pin_hash_collisions", hash_collisions, mp_hc);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [255:0] h3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] f);
        logic [255:0] v = {32{f}};
        v[7:0]   = a;
        v[15:8]  = b;
        v[23:16] = c;
        return v;
    endfunction

    function automatic logic [255:0] ramp(input int base);
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[8*k +: 8] = 8'(base + k);
        return v;
    endfunction

    task automatic drive(input logic [255:0] d, input logic [255:0] dc, input bit pe,
                         input bit pf, input int pl, input int pd, input logic [7:0] plit,
                         input int pmc, input int phc);
        @(posedge clk);
        #1;
        data_in = d; dictionary = dc; data_valid = 1'b1;
        pin_en = pe; pin_flag = pf; pin_len = pl; pin_dist = pd;
        pin_lit = plit; pin_mc = pmc; pin_hc = phc;
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        pin_en = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    logic [255:0] zero = '0;
    logic [255:0] thr_dict;

    initial begin
        thr_dict = '0;
        thr_dict[255:232] = 24'h414141;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(3);

        drive(zero, zero, 1, 0, 32, 1, 8'h00, 1, 0);
        drive(ramp(8'h80), ramp(8'h80), 1, 0, 32, 32, 8'h80, 2, 0);
        drive(ramp(1), zero, 1, 1, 0, 0, 8'h01, 2, 0);
        idle(2);
        drive(h3(8'h41, 8'h41, 8'h00, 8'hFF), thr_dict, 1, 1, 0, 0, 8'h41, 2, 0);
        idle(2);
        drive(h3(8'h41, 8'h41, 8'h41, 8'hFF), thr_dict, 1, 0, 3, 1, 8'h41, 3, 0);
        idle(3);

        // Four back-to-back beats, all in hash bucket 1.
        drive(h3(8'h01, 8'h00, 8'h00, 8'hFF), zero, 1, 1, 0, 0, 8'h01, 3, 0);
        drive(h3(8'h11, 8'h00, 8'h00, 8'hFF), zero, 1, 1, 0, 0, 8'h11, 3, 1);
        drive(h3(8'h01, 8'h00, 8'h00, 8'hFF), zero, 1, 1, 0, 0, 8'h01, 3, 2);
        drive(h3(8'h01, 8'h00, 8'h00, 8'hFF), zero, 1, 1, 0, 0, 8'h01, 3, 2);
        idle(3);

        // Reset lands right after a beat is accepted, discarding its result.
        drive(zero, zero, 0, 0, 0, 0, 8'h00, 0, 0);
        drive(ramp(8'h80), ramp(8'h80), 0, 0, 0, 0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        data_valid = 1'b0;
        pin_en = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(2);
        drive(h3(8'h11, 8'h00, 8'h00, 8'hFF), zero, 1, 1, 0, 0, 8'h11, 0, 0);
        drive(h3(8'h01, 8'h00, 8'h00, 8'hFF), zero, 1, 1, 0, 0, 8'h01, 0, 1);
        drive(zero, zero, 1, 0, 32, 1, 8'h00, 1, 1);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
